// File: rtl/horner_pkg.sv
// Shared types and constants for the Horner correction sequencer.
// Optional feature macro used by the top: HORNER_TIMEOUT_EN.
package horner_pkg;

  localparam int          FLOAT_W    = 32;
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;
  localparam int          COEF_AW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/horner_coef_bank.sv
// Coefficient register file: (ORDER+1) x FLOAT_W words, synchronous write,
// asynchronous read by index, synchronous clear on reset.
// Writes to an index above ORDER match no entry and are dropped.
module horner_coef_bank
  import horner_pkg::*;
#(
  parameter int ORDER = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COEF_AW-1:0] wr_addr,
  input  logic [FLOAT_W-1:0] wr_data,
  input  logic [COEF_AW-1:0] rd_addr,
  output logic [FLOAT_W-1:0] rd_data
);

  logic [FLOAT_W-1:0] mem [ORDER+1];

  // Write port; the index compare keeps out-of-range addresses from aliasing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= ORDER; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i <= ORDER; i++) begin
        if (wr_addr == COEF_AW'(i)) mem[i] <= wr_data;
      end
    end
  end

  // Read mux by index.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= ORDER; i++) begin
      if (rd_addr == COEF_AW'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/horner_correction_sequencer.sv
// Sequences a pulse-handshake multiply-add engine through Horner's method
// to evaluate a per-channel correction polynomial of order ORDER.
// Optional macro HORNER_TIMEOUT_EN adds a per-transaction watchdog that
// forces a qNaN result and sets the sticky timeout_err flag.
//
// state | meaning
// IDLE  | waiting for a sample
// ISSUE | mac_data_in_ready high; operands acc, x, c_k presented
// WAIT  | waiting for the engine's completion pulse
// DONE  | result_ready high for one cycle
module horner_correction_sequencer
  import horner_pkg::*;
#(
  parameter int ORDER          = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOAT_W-1:0] sample_in,
  input  logic               sample_in_ready,
  input  logic               coef_wr_en,
  input  logic [COEF_AW-1:0] coef_wr_addr,
  input  logic [FLOAT_W-1:0] coef_wr_data,
  output logic [FLOAT_W-1:0] mac_data_1,
  output logic [FLOAT_W-1:0] mac_data_2,
  output logic [FLOAT_W-1:0] mac_data_3,
  output logic               mac_data_in_ready,
  input  logic [FLOAT_W-1:0] mac_data_out,
  input  logic               mac_data_out_ready,
  output logic [FLOAT_W-1:0] result,
  output logic               result_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [COEF_AW-1:0] TOP_IDX = COEF_AW'(ORDER);
  localparam logic [COEF_AW-1:0] START_K = COEF_AW'((ORDER > 0) ? ORDER - 1 : 0);
  localparam logic [COEF_AW-1:0] K_ONE   = COEF_AW'(1);

  state_t             state_q, state_d;
  logic [FLOAT_W-1:0] acc_q, acc_d;
  logic [FLOAT_W-1:0] x_q, x_d;
  logic [FLOAT_W-1:0] res_q, res_d;
  logic [COEF_AW-1:0] k_q, k_d;
  logic [COEF_AW-1:0] coef_rd_addr;
  logic [FLOAT_W-1:0] coef_rd;
  logic               busy_int;

`ifdef HORNER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             terr_q, terr_d;
`endif

  assign busy_int = (state_q == ISSUE) || (state_q == WAIT);

  // Outside an evaluation the read port looks at c_N so acceptance can seed acc.
  assign coef_rd_addr = busy_int ? k_q : TOP_IDX;

  horner_coef_bank #(.ORDER(ORDER)) u_coef_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (coef_wr_en && !busy_int),
    .wr_addr (coef_wr_addr),
    .wr_data (coef_wr_data),
    .rd_addr (coef_rd_addr),
    .rd_data (coef_rd)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    k_d     = k_q;
    res_d   = res_q;
`ifdef HORNER_TIMEOUT_EN
    tmo_d   = tmo_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (sample_in_ready) begin
          x_d   = sample_in;
          acc_d = coef_rd;
          k_d   = START_K;
`ifdef HORNER_TIMEOUT_EN
          terr_d = 1'b0;
`endif
          if (ORDER == 0) begin
            state_d = DONE;
            res_d   = coef_rd;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef HORNER_TIMEOUT_EN
        tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
      end
      WAIT: begin
        if (mac_data_out_ready) begin
          acc_d = mac_data_out;
          if (k_q == '0) begin
            state_d = DONE;
            res_d   = mac_data_out;
          end else begin
            k_d     = k_q - K_ONE;
            state_d = ISSUE;
          end
        end
`ifdef HORNER_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = DONE;
          res_d   = FLOAT_QNAN;
          terr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      res_q   <= res_d;
      k_q     <= k_d;
    end
  end

`ifdef HORNER_TIMEOUT_EN
  // Watchdog down-counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mac_data_1        = acc_q;
  assign mac_data_2        = x_q;
  assign mac_data_3        = coef_rd;
  assign mac_data_in_ready = (state_q == ISSUE);
  assign result            = res_q;
  assign result_ready      = (state_q == DONE);
  assign busy              = busy_int;

endmodule

// File: doc/horner_correction_sequencer.md
# horner_correction_sequencer

Drives a multiply-add engine (pulse-handshake `data_in_ready`/`data_out_ready`, IEEE-754 single precision `a*b+c`) to evaluate a per-channel ADC correction polynomial by Horner's method. It sits between the raw-sample capture logic and the multiply-add engine. It owns the coefficient bank, issues one multiply-add per polynomial order and returns the corrected sample with a one-cycle `result_ready` pulse. The block does no arithmetic itself: it only sequences and routes 32-bit words.

## Interface
- `ORDER`, 3: polynomial order N (0..15); N+1 coefficients c_N..c_0.
- `TIMEOUT_CYCLES`, 1023: watchdog limit per multiply-add transaction. Used only with `HORNER_TIMEOUT_EN`.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `sample_in`, in, 32: raw sample x as a float.
- `sample_in_ready`, in, 1: one-cycle pulse; x is valid in that cycle.
- `coef_wr_en`, in, 1: coefficient write strobe.
- `coef_wr_addr`, in, 4: coefficient index k (c_k).
- `coef_wr_data`, in, 32: coefficient value.
- `mac_data_1`, out, 32: multiplicand; carries the accumulator.
- `mac_data_2`, out, 32: multiplier; carries the latched x.
- `mac_data_3`, out, 32: addend; carries c_k.
- `mac_data_in_ready`, out, 1: one-cycle issue pulse to the engine.
- `mac_data_out`, in, 32: engine result.
- `mac_data_out_ready`, in, 1: one-cycle engine completion pulse.
- `result`, out, 32: corrected sample p(x); held until the next result.
- `result_ready`, out, 1: one-cycle pulse.
- `busy`, out, 1: high from sample acceptance until `result_ready`. Low during the `result_ready` cycle.
- `timeout_err`, out, 1: sticky error flag. Cleared when the next sample is accepted.

## Operation
- States:
  - IDLE: waits for a sample.
  - ISSUE: drives `mac_data_in_ready`.
  - WAIT: waits for the engine to respond.
  - DONE: drives `result_ready`.
- IDLE, on `sample_in_ready`:
  - latch x;
  - set acc = c_N and step k = N-1;
  - go to ISSUE.
  - If N = 0, go straight to DONE with acc = c_0.
- ISSUE:
  - drive `mac_data_1/2/3` = acc, x, c_k and hold them stable through WAIT;
  - pulse `mac_data_in_ready` for exactly one cycle;
  - go to WAIT.
- WAIT, on `mac_data_out_ready`:
  - capture acc = `mac_data_out`;
  - if k = 0, go to DONE; otherwise decrement k and go to ISSUE.
- DONE:
  - `result` = acc and `result_ready` = 1 for one cycle;
  - if `sample_in_ready` is high in that cycle, accept the new sample and go to ISSUE (back-to-back); otherwise go to IDLE.
- `sample_in_ready` is ignored while `busy` = 1. No queueing.
- `mac_data_out_ready` is ignored in IDLE, ISSUE and DONE. Spurious responses are dropped.
- Coefficient writes are accepted only when `busy` = 0, and are dropped otherwise. Coefficients are therefore stable for a whole evaluation.
- Writes with `coef_wr_addr` > N are dropped.
- Reset, including mid-operation:
  - state goes to IDLE;
  - all outputs go to 0 (`result`, `mac_data_*`, pulses, `busy`, `timeout_err`);
  - all coefficients go to 0x00000000;
  - an engine response that arrives after reset is ignored.

## Timing
- `sample_in_ready` high at cycle 0 → first `mac_data_in_ready` at cycle 1.
- For an engine latency L (issue pulse to response pulse): the response for step j arrives at cycle j(L+1), and the next issue follows in the next cycle.
- `result_ready` is high at cycle N(L+1)+1.
- N = 0: `result_ready` at cycle 1 and no engine transactions.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- `HORNER_TIMEOUT_EN` defined:
  - a cycle counter runs in WAIT;
  - reaching `TIMEOUT_CYCLES` without `mac_data_out_ready` forces DONE with `result` = 0x7FC00000 (qNaN), `result_ready` = 1 and `timeout_err` = 1.
- Not defined: no counter is built; WAIT waits indefinitely and `timeout_err` is tied to 0.

## Structure
- Package `horner_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/DONE);
  - the `FLOAT_W` = 32 constant;
  - the `FLOAT_QNAN` = 32'h7FC00000 constant;
  - the coefficient address width.
- Sub-module `horner_coef_bank` holds the (N+1)x32 register file: synchronous write, asynchronous read by index, synchronous clear on `reset`.

## Test plan
- Basic evaluation:
  - Setup: N=2; c2=0x3F800000 (1.0), c1=0x40000000 (2.0), c0=0x40400000 (3.0); x=0x40000000 (2.0); behavioural engine with L=4.
  - Required issues: (0x3F800000, 0x40000000, 0x40000000), then (0x40800000, 0x40000000, 0x40400000).
  - Required result: `result` = 0x41300000 (11.0) with `result_ready` at cycle 11.
- N=0 with c0=0x40A00000 → `result` = 0x40A00000 at cycle 1, and `mac_data_in_ready` never asserts.
- Drops while busy:
  - A second `sample_in_ready` while `busy` → ignored and only one `result_ready` pulse.
  - A coefficient write while `busy` → the coefficient is unchanged on the next evaluation.
  - `sample_in_ready` in the DONE cycle → a new issue on the following cycle with no idle gap.
- Reset mid-operation:
  - Assert `reset` in WAIT, then let the engine respond → no `result_ready`, and all outputs and coefficients are 0.
- With `HORNER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8:
  - Engine never responds → `result` = 0x7FC00000 and `timeout_err` = 1.
  - The next accepted sample clears `timeout_err`.
- Spurious `mac_data_out_ready` in IDLE → no state change and no `result_ready`.
